// File: rtl/fifo_wconv_pkg.sv
// Shared width helpers for the width-converting FIFO.
package fifo_wconv_pkg;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Write pointer counts words with one wrap bit.
   function automatic int unsigned wptr_w(input int unsigned depth);
      return clog2(depth) + 1;
   endfunction

   // Read pointer and level count read units with one wrap bit.
   function automatic int unsigned rptr_w(input int unsigned depth, input int unsigned ratio);
      return clog2(depth * ratio) + 1;
   endfunction

   localparam int unsigned DEF_RD_W   = 8;
   localparam int unsigned DEF_RATIO  = 4;
   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned DEF_WPTR_W = wptr_w(DEF_DEPTH);
   localparam int unsigned DEF_LVL_W  = rptr_w(DEF_DEPTH, DEF_RATIO);

endpackage

// File: rtl/fifo_wconv_lanesel.sv
// Picks one read unit out of a stored word, in either lane order.
module fifo_wconv_lanesel
   import fifo_wconv_pkg::*;
#(
   parameter int unsigned RD_W      = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic [RD_W*RATIO-1:0]    word,
   input  logic [clog2(RATIO)-1:0]  lane,
   output logic [RD_W-1:0]          unit
);

   localparam int unsigned LANE_W = clog2(RATIO);

   logic [LANE_W-1:0] sel;

   always_comb begin
      sel  = (MSB_FIRST != 0) ? LANE_W'(RATIO - 1) - lane : lane;
      unit = '0;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (sel == LANE_W'(i)) unit = word[i*RD_W +: RD_W];
      end
   end

endmodule

// File: rtl/fifo_wconv.sv
// Wide-in / narrow-out FIFO: whole words written, single lanes read, FWFT.
module fifo_wconv
   import fifo_wconv_pkg::*;
#(
   parameter int unsigned RD_W      = 8,
   parameter int unsigned RATIO     = 4,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned MSB_FIRST = 0,
   parameter int unsigned AFULL_TH  = DEPTH - 1
) (
   input  logic                             sclk,
   input  logic                             rst,
   input  logic                             clr_i,
   input  logic [RD_W*RATIO-1:0]            wdata_i,
   input  logic                             wr_i,
   output logic [RD_W-1:0]                  rdata_o,
   input  logic                             rd_i,
   output logic                             empty_o,
   output logic                             full_o,
   output logic                             afull_o,
   output logic [rptr_w(DEPTH, RATIO)-1:0]  level_o,
   output logic                             ovf_o,
   output logic                             udf_o
);

   localparam int unsigned WW     = RD_W * RATIO;
   localparam int unsigned WP_W   = wptr_w(DEPTH);
   localparam int unsigned RP_W   = rptr_w(DEPTH, RATIO);
   localparam int unsigned LANE_W = clog2(RATIO);
   localparam int unsigned ADDR_W = WP_W - 1;

   logic [WP_W-1:0]   wptr;
   logic [RP_W-1:0]   rptr;
   logic [WW-1:0]     mem [DEPTH];
   logic [RP_W-1:0]   wscaled;
   logic [RD_W-1:0]   lane_data;
   logic              wr_en;
   logic              rd_en;
   logic              flush;

   // Word pointer scaled to read units; level follows from pointer difference.
   assign wscaled = RP_W'({wptr, {LANE_W{1'b0}}});
   assign level_o = wscaled - rptr;
   assign empty_o = (level_o == '0);
   assign full_o  = (level_o > RP_W'((DEPTH - 1) * RATIO));
   assign afull_o = (level_o >= RP_W'(AFULL_TH * RATIO));

   assign wr_en = wr_i && !full_o;
   assign rd_en = rd_i && !empty_o;
   assign flush = rst || clr_i;

   always_ff @(posedge sclk) begin
      if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + WP_W'(1);
         if (rd_en) rptr <= rptr + RP_W'(1);
         if (wr_i && full_o) ovf_o <= 1'b1;
         if (rd_i && empty_o) udf_o <= 1'b1;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge sclk) begin
      if (wr_en && !flush) mem[wptr[ADDR_W-1:0]] <= wdata_i;
   end

   fifo_wconv_lanesel #(
      .RD_W      (RD_W),
      .RATIO     (RATIO),
      .MSB_FIRST (MSB_FIRST)
   ) u_lanesel (
      .word (mem[rptr[RP_W-2:LANE_W]]),
      .lane (rptr[LANE_W-1:0]),
      .unit (lane_data)
   );

   assign rdata_o = empty_o ? '0 : lane_data;

endmodule

// File: tb/tb_fifo_wconv.sv
// Randomized bench for fifo_wconv against a queue-of-bytes reference model.
module tb_fifo_wconv;

   logic        sclk;
   logic        rst;
   logic        clr_i;
   logic        wr_i;
   logic        rd_i;
   logic [31:0] wdata_i;

   logic [7:0]  rdata, rdata_m;
   logic [4:0]  level, level_m;
   logic        empty, full, afull, ovf, udf;
   logic        empty_m, full_m, afull_m, ovf_m, udf_m;

   int checks = 0;
   int errors = 0;

   // Reference model: pending read units in LSB-first and MSB-first order.
   logic [7:0] q_l[$];
   logic [7:0] q_m[$];
   logic       m_ovf;
   logic       m_udf;

   fifo_wconv dut (
      .sclk(sclk), .rst(rst), .clr_i(clr_i), .wdata_i(wdata_i), .wr_i(wr_i),
      .rdata_o(rdata), .rd_i(rd_i), .empty_o(empty), .full_o(full),
      .afull_o(afull), .level_o(level), .ovf_o(ovf), .udf_o(udf)
   );

   fifo_wconv #(.MSB_FIRST(1)) dut_m (
      .sclk(sclk), .rst(rst), .clr_i(clr_i), .wdata_i(wdata_i), .wr_i(wr_i),
      .rdata_o(rdata_m), .rd_i(rd_i), .empty_o(empty_m), .full_o(full_m),
      .afull_o(afull_m), .level_o(level_m), .ovf_o(ovf_m), .udf_o(udf_m)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] exp_l();
      return (q_l.size() != 0) ? q_l[0] : 8'h00;
   endfunction

   function automatic logic [7:0] exp_m();
      return (q_m.size() != 0) ? q_m[0] : 8'h00;
   endfunction

   // Drive one cycle, advance the model on the same edge, settle past the edge.
   task automatic step(input logic w, input logic r, input logic c, input logic rs,
                       input logic [31:0] d);
      int lvl;
      wr_i = w; rd_i = r; clr_i = c; rst = rs; wdata_i = d;
      @(posedge sclk);
      lvl = q_l.size();
      if (rs || c) begin
         q_l.delete(); q_m.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      end else begin
         if (r) begin
            if (lvl == 0) m_udf = 1'b1;
            else begin void'(q_l.pop_front()); void'(q_m.pop_front()); end
         end
         if (w) begin
            if (lvl > 12) m_ovf = 1'b1;
            else for (int k = 0; k < 4; k++) begin
               q_l.push_back(d[8*k +: 8]);
               q_m.push_back(d[8*(3-k) +: 8]);
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(0, 0, 0, 1, 32'h0);
      checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
      checks++; if (afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", afull); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", rdata); end
      checks++; if (rdata_m !== 8'h00) begin errors++; $display("FAIL reset_rdata_m: got %02h expected 00", rdata_m); end
      checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_sticky: got ovf=%b udf=%b expected 0 0", ovf, udf); end
   endtask

   task automatic test_basic();
      logic [7:0] el [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] em [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      step(0, 0, 0, 1, 32'h0);
      step(1, 0, 0, 0, 32'h44332211);
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_not_empty: got %b expected 0", empty); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (level !== 5'(4 - i)) begin errors++; $display("FAIL basic_level[%0d]: got %0d expected %0d", i, level, 4 - i); end
         checks++; if (rdata !== el[i]) begin errors++; $display("FAIL basic_rdata[%0d]: got %02h expected %02h", i, rdata, el[i]); end
         checks++; if (rdata_m !== em[i]) begin errors++; $display("FAIL basic_rdata_msb[%0d]: got %02h expected %02h", i, rdata_m, em[i]); end
         step(0, 1, 0, 0, 32'h0);
      end
      checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL basic_drained: got level=%0d empty=%b expected 0 1", level, empty); end
      checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL basic_rdata_empty: got %02h expected 00", rdata); end
   endtask

   task automatic test_overflow();
      logic [31:0] w [4];
      logic [7:0]  el, em;
      step(0, 0, 0, 1, 32'h0);
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         step(1, 0, 0, 0, w[i]);
      end
      checks++; if (full !== 1'b1 || level !== 5'd16) begin errors++; $display("FAIL ovf_full: got full=%b level=%0d expected 1 16", full, level); end
      checks++; if (afull !== 1'b1) begin errors++; $display("FAIL ovf_afull: got %b expected 1", afull); end
      step(1, 0, 0, 0, $urandom);
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
      checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
      for (int i = 0; i < 16; i++) begin
         el = w[i/4][8*(i%4) +: 8];
         em = w[i/4][8*(3-(i%4)) +: 8];
         checks++; if (rdata !== el) begin errors++; $display("FAIL ovf_data[%0d]: got %02h expected %02h", i, rdata, el); end
         checks++; if (rdata_m !== em) begin errors++; $display("FAIL ovf_data_msb[%0d]: got %02h expected %02h", i, rdata_m, em); end
         step(0, 1, 0, 0, 32'h0);
      end
      checks++; if (empty !== 1'b1 || ovf !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL ovf_after: got empty=%b ovf=%b udf=%b expected 1 1 0", empty, ovf, udf); end
   endtask

   task automatic test_thresholds();
      logic [31:0] d;
      step(0, 0, 0, 1, 32'h0);
      step(1, 0, 0, 0, $urandom);
      step(1, 0, 0, 0, $urandom);
      checks++; if (level !== 5'd8 || afull !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL th_level8: got level=%0d afull=%b full=%b expected 8 0 0", level, afull, full); end
      step(1, 0, 0, 0, $urandom);
      checks++; if (level !== 5'd12 || afull !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL th_level12: got level=%0d afull=%b full=%b expected 12 1 0", level, afull, full); end
      step(1, 1, 0, 0, $urandom);
      checks++; if (level !== 5'd15 || full !== 1'b1) begin errors++; $display("FAIL th_wr_rd: got level=%0d full=%b expected 15 1", level, full); end
      checks++; if (rdata !== exp_l()) begin errors++; $display("FAIL th_rdata: got %02h expected %02h", rdata, exp_l()); end
      for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 32'h0);
      checks++; if (empty !== 1'b1 || udf !== 1'b0) begin errors++; $display("FAIL th_drain: got empty=%b udf=%b expected 1 0", empty, udf); end
      step(0, 1, 0, 0, 32'h0);
      checks++; if (udf !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL th_udf: got udf=%b level=%0d expected 1 0", udf, level); end
      d = $urandom;
      step(1, 0, 0, 0, d);
      checks++; if (level !== 5'd4 || rdata !== d[7:0]) begin errors++; $display("FAIL th_rptr_kept: got level=%0d rdata=%02h expected 4 %02h", level, rdata, d[7:0]); end
      step(0, 0, 0, 1, 32'h0);
      d = $urandom;
      step(1, 1, 0, 0, d);
      checks++; if (udf !== 1'b1 || level !== 5'd4 || rdata !== d[7:0]) begin errors++; $display("FAIL th_first_wr_rd: got udf=%b level=%0d rdata=%02h expected 1 4 %02h", udf, level, rdata, d[7:0]); end
   endtask

   task automatic test_stream();
      int   sent = 0;
      int   cyc  = 0;
      logic w, r;
      step(0, 0, 0, 1, 32'h0);
      while ((sent < 40 || q_l.size() != 0) && cyc < 3000) begin
         w = (sent < 40) && (q_l.size() <= 12) && ($urandom_range(0, 3) != 0);
         r = (q_l.size() != 0) && ($urandom_range(0, 1) == 1);
         step(w, r, 0, 0, $urandom);
         if (w) sent++;
         cyc++;
         checks++; if (level !== 5'(q_l.size())) begin errors++; $display("FAIL stream_level@%0d: got %0d expected %0d", cyc, level, q_l.size()); end
         checks++; if (rdata !== exp_l()) begin errors++; $display("FAIL stream_rdata@%0d: got %02h expected %02h", cyc, rdata, exp_l()); end
         checks++; if (rdata_m !== exp_m()) begin errors++; $display("FAIL stream_rdata_msb@%0d: got %02h expected %02h", cyc, rdata_m, exp_m()); end
         checks++; if (empty !== (q_l.size() == 0) || full !== (q_l.size() > 12) || afull !== (q_l.size() >= 12)) begin
            errors++; $display("FAIL stream_flags@%0d: got e=%b f=%b af=%b for level %0d", cyc, empty, full, afull, q_l.size());
         end
         checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL stream_sticky@%0d: got ovf=%b udf=%b expected 0 0", cyc, ovf, udf); end
      end
      checks++; if (sent != 40 || q_l.size() != 0) begin errors++; $display("FAIL stream_done: got sent=%0d left=%0d expected 40 0", sent, q_l.size()); end
   endtask

   task automatic test_clear();
      for (int mode = 0; mode < 2; mode++) begin
         step(0, 0, 0, 1, 32'h0);
         step(0, 1, 0, 0, 32'h0);
         for (int i = 0; i < 5; i++) step(1, 0, 0, 0, $urandom);
         for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 32'h0);
         checks++; if (level !== 5'd7 || ovf !== 1'b1 || udf !== 1'b1) begin errors++; $display("FAIL clr%0d_setup: got level=%0d ovf=%b udf=%b expected 7 1 1", mode, level, ovf, udf); end
         if (mode == 0) step(1, 0, 1, 0, $urandom);
         else           step(1, 0, 0, 1, $urandom);
         checks++; if (level !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr%0d_level: got level=%0d empty=%b expected 0 1", mode, level, empty); end
         checks++; if (ovf !== 1'b0 || udf !== 1'b0 || full !== 1'b0 || afull !== 1'b0) begin
            errors++; $display("FAIL clr%0d_flags: got ovf=%b udf=%b full=%b afull=%b expected 0 0 0 0", mode, ovf, udf, full, afull);
         end
         checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL clr%0d_rdata: got %02h expected 00", mode, rdata); end
         step(0, 0, 0, 0, 32'h0);
         checks++; if (level !== 5'(q_l.size()) || level !== 5'd0) begin errors++; $display("FAIL clr%0d_dropped: got level=%0d expected 0", mode, level); end
      end
   endtask

   initial begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_thresholds();
      test_stream();
      test_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_wconv.md
FIFO_WCONV -- requirements
Module: fifo_wconv

Interface
REQ-001 SHALL have parameter RD_W, default 8: read-side data width in bits.
REQ-002 SHALL have parameter RATIO, default 4: read units per write word; power of 2, 2..16.
REQ-003 SHALL have parameter DEPTH, default 4: storage depth in write words; power of 2, >= 2.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 = lowest lane of a word read first; 1 = highest lane first.
REQ-005 SHALL have parameter AFULL_TH, default DEPTH-1: almost-full threshold, in write words.
REQ-006 SHALL have port sclk, input, 1: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port clr_i, input, 1: synchronous flush.
REQ-009 SHALL have port wdata_i, input, RD_W*RATIO: write word.
REQ-010 SHALL have port wr_i, input, 1: write request.
REQ-011 SHALL have port rdata_o, output, RD_W: head read unit (first-word fall-through).
REQ-012 SHALL have port rd_i, input, 1: pop one read unit.
REQ-013 SHALL have ports empty_o, full_o, afull_o, each output, 1: status flags.
REQ-014 SHALL have port level_o, output, clog2(DEPTH*RATIO)+1: fill level in read units.
REQ-015 SHALL have ports ovf_o and udf_o, each output, 1: sticky overflow and underflow flags.

Function
REQ-016 Write pointer SHALL count words, clog2(DEPTH)+1 bits; read pointer SHALL count read units, clog2(DEPTH*RATIO)+1 bits; both wrap modulo 2x capacity.
REQ-017 level_o SHALL equal (wptr*RATIO - rptr), truncated to the level_o width; it is derived from the pointers registered in the previous cycle.
REQ-018 empty_o SHALL be 1 iff level_o == 0.
REQ-019 full_o SHALL be 1 iff level_o > (DEPTH-1)*RATIO, i.e. room for less than one whole word.
REQ-020 afull_o SHALL be 1 iff level_o >= AFULL_TH*RATIO.
REQ-021 A write SHALL be accepted iff wr_i && !full_o; on acceptance the word is stored at wptr and wptr increments by 1.
REQ-022 A read SHALL be accepted iff rd_i && !empty_o; on acceptance rptr increments by 1.
REQ-023 A simultaneous accepted write and read SHALL change the level by RATIO-1; flags are evaluated on pre-edge state only (no bypass).
REQ-024 rd_i on the same cycle as the first write into an empty FIFO SHALL be ignored and SHALL set udf_o.
REQ-025 rdata_o SHALL be combinational from storage at rptr: lane = rptr low bits when MSB_FIRST=0, and RATIO-1 minus those bits when MSB_FIRST=1; rdata_o SHALL be 0 while empty_o=1.
REQ-026 A refused write (wr_i && full_o) SHALL set ovf_o, leave wptr and storage unchanged, and leave the read path unaffected.
REQ-027 A refused read (rd_i && empty_o) SHALL set udf_o and leave rptr unchanged.
REQ-028 ovf_o and udf_o SHALL clear only on rst or clr_i.
REQ-029 clr_i SHALL zero both pointers, ovf_o and udf_o at the next edge and SHALL have priority over wr_i and rd_i in the same cycle.

Reset
REQ-030 On rst=1 at a clock edge: pointers SHALL be 0, ovf_o and udf_o 0, giving empty_o=1, full_o=0, afull_o=0, level_o=0 and rdata_o=0.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 rst SHALL have priority over clr_i, wr_i and rd_i, including in the middle of a stream.

Structure
REQ-033 A package fifo_wconv_pkg SHALL hold the clog2 function and the pointer- and level-width constants derived from the parameters.
REQ-034 The lane-select multiplexer SHALL be one sub-module, fifo_wconv_lanesel, parameterised by RD_W, RATIO and MSB_FIRST.
REQ-035 The storage SHALL be a DEPTH x (RD_W*RATIO) register array; no other sub-modules.

Verification
REQ-036 Defaults; reset; write 0x44332211; 4 reads -> rdata_o 0x11, 0x22, 0x33, 0x44; level_o 4,3,2,1,0; empty_o=1 after.
REQ-037 MSB_FIRST=1; same stimulus -> rdata_o 0x44, 0x33, 0x22, 0x11.
REQ-038 4 writes -> full_o=1, level_o=16; 5th write -> ovf_o=1, level_o stays 16; 16 reads return the first 4 words intact.
REQ-039 Level 12 (full_o=0, afull_o=1); wr_i and rd_i together -> level_o=15, full_o=1; rd_i on an empty FIFO -> udf_o=1, rptr unchanged.
REQ-040 Stream 40 words with random read gaps so both pointers wrap -> read-side byte sequence matches a reference model, with no ovf_o or udf_o.
REQ-041 clr_i, and separately rst, asserted mid-stream at level 7 with wr_i=1 -> next cycle level_o=0, empty_o=1, flags 0, and the write is dropped.
